// File: rtl/pci_arbiter.sv
// Round-robin PCI bus arbiter with a four-state grant FSM and a grant timeout.
// All outputs are registered; reset is synchronous and active-low.
module pci_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int GNT_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_MASTERS-1:0] req,
    input  logic                   frame,
    input  logic                   irdy,
    output logic [NUM_MASTERS-1:0] gnt,
    output logic [2:0]             owner,
    output logic                   bus_busy,
    output logic                   timeout_err
);

    localparam int CNT_W = $clog2(GNT_TIMEOUT) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BUSY  = 2'd2,
        ST_TURN  = 2'd3
    } state_t;

    state_t                   state_r, state_s;
    logic [NUM_MASTERS-1:0]   gnt_r, gnt_s;
    logic [2:0]               owner_r, owner_s;
    logic [2:0]               rr_ptr_r, rr_ptr_s;
    logic [CNT_W-1:0]         wait_cnt_r, wait_cnt_s;
    logic                     bus_busy_r, bus_busy_s;
    logic                     timeout_err_r, timeout_err_s;
    logic [2*NUM_MASTERS-1:0] req_rot_s;
    logic [2:0]               winner_s;
    logic                     any_req_s;
    logic                     owner_req_s;
    int                       idx_s;

    // Round-robin search: rotate req so rr_ptr sits at bit 0, take the lowest set bit.
    always_comb begin
        req_rot_s = {req, req} >> rr_ptr_r;
        winner_s  = 3'd0;
        any_req_s = 1'b0;
        idx_s     = 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!any_req_s && req_rot_s[i]) begin
                any_req_s = 1'b1;
                idx_s     = int'(rr_ptr_r) + i;
                if (idx_s >= NUM_MASTERS) begin
                    idx_s = idx_s - NUM_MASTERS;
                end else begin
                    idx_s = idx_s;
                end
                winner_s = 3'(idx_s);
            end else begin
                winner_s = winner_s;
            end
        end
    end

    // The granted vector is one-hot at the owner, so this is req[owner] while granted.
    assign owner_req_s = |(req & gnt_r);

    // Next-state and next-output logic for the grant FSM.
    always_comb begin
        state_s       = state_r;
        gnt_s         = gnt_r;
        owner_s       = owner_r;
        rr_ptr_s      = rr_ptr_r;
        wait_cnt_s    = wait_cnt_r;
        timeout_err_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_s    = ST_GRANT;
                    gnt_s      = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << winner_s;
                    owner_s    = winner_s;
                    wait_cnt_s = {CNT_W{1'b0}};
                end else begin
                    gnt_s = {NUM_MASTERS{1'b0}};
                end
            end
            ST_GRANT: begin
                // frame takes priority over a dropped request in the same cycle
                if (!frame) begin
                    state_s = ST_BUSY;
                end else if (!owner_req_s) begin
                    state_s = ST_TURN;
                    gnt_s   = {NUM_MASTERS{1'b0}};
                end else if (wait_cnt_r == CNT_W'(GNT_TIMEOUT - 1)) begin
                    state_s       = ST_TURN;
                    gnt_s         = {NUM_MASTERS{1'b0}};
                    timeout_err_s = 1'b1;
                end else begin
                    wait_cnt_s = wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_BUSY: begin
                if (frame && irdy) begin
                    state_s = ST_TURN;
                    gnt_s   = {NUM_MASTERS{1'b0}};
                end else begin
                    state_s = ST_BUSY;
                end
            end
            ST_TURN: begin
                state_s    = ST_IDLE;
                gnt_s      = {NUM_MASTERS{1'b0}};
                wait_cnt_s = {CNT_W{1'b0}};
                if (owner_r == 3'(NUM_MASTERS - 1)) begin
                    rr_ptr_s = 3'd0;
                end else begin
                    rr_ptr_s = owner_r + 3'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                gnt_s   = {NUM_MASTERS{1'b0}};
            end
        endcase
        bus_busy_s = (state_s == ST_BUSY);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            gnt_r         <= {NUM_MASTERS{1'b0}};
            owner_r       <= 3'd0;
            rr_ptr_r      <= 3'd0;
            wait_cnt_r    <= {CNT_W{1'b0}};
            bus_busy_r    <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            gnt_r         <= gnt_s;
            owner_r       <= owner_s;
            rr_ptr_r      <= rr_ptr_s;
            wait_cnt_r    <= wait_cnt_s;
            bus_busy_r    <= bus_busy_s;
            timeout_err_r <= timeout_err_s;
        end
    end

    assign gnt         = gnt_r;
    assign owner       = owner_r;
    assign bus_busy    = bus_busy_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_pci_arbiter.sv
// Directed self-checking bench for pci_arbiter (NUM_MASTERS=4, GNT_TIMEOUT=16).
module tb_pci_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       frame;
    logic       irdy;
    logic [3:0] gnt;
    logic [2:0] owner;
    logic       bus_busy;
    logic       timeout_err;

    int n_cmp = 0;
    int n_err = 0;

    pci_arbiter #(.NUM_MASTERS(4), .GNT_TIMEOUT(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .frame       (frame),
        .irdy        (irdy),
        .gnt         (gnt),
        .owner       (owner),
        .bus_busy    (bus_busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge, settle, and confirm gnt is one-hot or zero.
    task automatic cycle();
        @(posedge clk);
        #1;
        chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    endtask

    initial begin
        logic [2:0] rot_exp [3];
        rot_exp[0] = 3'd2;
        rot_exp[1] = 3'd3;
        rot_exp[2] = 3'd0;

        rst_n = 1'b0;
        req   = 4'b0000;
        frame = 1'b1;
        irdy  = 1'b1;
        cycle();
        cycle();
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_owner", owner, 3'd0);
        chk("rst_busy", bus_busy, 1'b0);
        chk("rst_tmo", timeout_err, 1'b0);

        // First grant from reset: rr_ptr=0, lowest requester is master 1.
        rst_n = 1'b1;
        req   = 4'b0110;
        cycle();
        chk("a_gnt", gnt, 4'b0010);
        chk("a_owner", owner, 3'd1);
        cycle();
        chk("a_gnt_hold", gnt, 4'b0010);
        chk("a_busy0", bus_busy, 1'b0);
        frame = 1'b0;
        cycle();
        chk("a_busy1", bus_busy, 1'b1);
        chk("a_gnt_busy", gnt, 4'b0010);
        // Only frame high with irdy low must not end the transaction.
        frame = 1'b1;
        irdy  = 1'b0;
        cycle();
        chk("a_busy_irdy", bus_busy, 1'b1);

        // End of master 1 transaction: two idle grant cycles, then master 2.
        irdy = 1'b1;
        cycle();
        chk("b_turn_gnt", gnt, 4'b0000);
        chk("b_turn_busy", bus_busy, 1'b0);
        cycle();
        chk("b_idle_gnt", gnt, 4'b0000);
        cycle();
        chk("b_gnt2", gnt, 4'b0100);
        chk("b_owner2", owner, 3'd2);

        // Master 2 drops its request while granted: grant released.
        req = 4'b0000;
        cycle();
        chk("b_drop_gnt", gnt, 4'b0000);
        chk("b_drop_tmo", timeout_err, 1'b0);
        cycle();
        cycle();
        chk("b_nopark", gnt, 4'b0000);

        // Timeout: rr_ptr=3, master 0 wins after wrap, frame never asserted.
        req = 4'b0001;
        cycle();
        chk("c_gnt0", gnt, 4'b0001);
        chk("c_owner0", owner, 3'd0);
        for (int k = 0; k < 15; k++) begin
            cycle();
        end
        chk("c_gnt_before_tmo", gnt, 4'b0001);
        chk("c_tmo_before", timeout_err, 1'b0);
        cycle();
        chk("c_tmo_gnt", gnt, 4'b0000);
        chk("c_tmo_pulse", timeout_err, 1'b1);
        cycle();
        chk("c_tmo_clear", timeout_err, 1'b0);
        chk("c_tmo_gnt_low", gnt, 4'b0000);
        cycle();
        chk("c_regnt0", gnt, 4'b0001);
        chk("c_regnt_owner", owner, 3'd0);

        // No preemption during BUSY, then rotation 1,2,3,0.
        frame = 1'b0;
        cycle();
        chk("d_busy", bus_busy, 1'b1);
        req = 4'b1111;
        cycle();
        req = 4'b1110;
        cycle();
        cycle();
        chk("d_nopreempt", gnt, 4'b0001);
        frame = 1'b1;
        cycle();
        chk("d_turn", gnt, 4'b0000);
        cycle();
        cycle();
        chk("d_gnt1", gnt, 4'b0010);
        chk("d_owner1", owner, 3'd1);
        req = 4'b1111;
        for (int m = 0; m < 3; m++) begin
            frame = 1'b0;
            cycle();
            chk("d_rot_busy", bus_busy, 1'b1);
            frame = 1'b1;
            cycle();
            chk("d_rot_turn", gnt, 4'b0000);
            cycle();
            chk("d_rot_idle", gnt, 4'b0000);
            cycle();
            chk("d_rot_owner", owner, rot_exp[m]);
            chk("d_rot_gnt", gnt, 4'b0001 << rot_exp[m]);
        end

        // Reset while busy drops everything; rr_ptr restarts at 0.
        frame = 1'b0;
        cycle();
        chk("e_busy", bus_busy, 1'b1);
        rst_n = 1'b0;
        req   = 4'b1000;
        cycle();
        chk("e_rst_gnt", gnt, 4'b0000);
        chk("e_rst_owner", owner, 3'd0);
        chk("e_rst_busy", bus_busy, 1'b0);
        rst_n = 1'b1;
        cycle();
        chk("e_gnt3", gnt, 4'b1000);
        chk("e_owner3", owner, 3'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
